// File: rtl/audio_interp_fifo_if.sv
// Sample-pair input channel between the audio mixer and the DAC-side interpolator.
// valid/ready: a pair transfers on every clk edge where in_valid and in_ready are both high;
// in_valid must not depend on in_ready, and in_l/in_r must be stable while in_valid is high.
interface audio_interp_fifo_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_l;
  logic [15:0] in_r;

  modport master (output in_valid, output in_l, output in_r, input in_ready);
  modport slave  (input in_valid, input in_l, input in_r, output in_ready);
endinterface

// File: rtl/audio_interp_fifo.sv
// Stereo FIFO plus linear interpolator feeding offset-binary samples to the PWM/sigma-delta DAC,
// one output update per PWM frame and 2^INTERP_LOG2 updates per input sample.
module audio_interp_fifo #(
  parameter int TICK_DIV    = 32,
  parameter int INTERP_LOG2 = 4,
  parameter int FIFO_LOG2   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  audio_interp_fifo_if.slave   in_bus,
  input  logic                 mute,
  output logic [15:0]          d_l,
  output logic [15:0]          d_r,
  output logic                 underrun,
  output logic [FIFO_LOG2:0]   fifo_level
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int ACC_W = 17 + INTERP_LOG2;

  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic                   tick_q;
  logic [INTERP_LOG2-1:0] phase;
  logic                   boundary;

  logic [31:0]            mem [DEPTH];
  logic [FIFO_LOG2-1:0]   wr_ptr;
  logic [FIFO_LOG2-1:0]   rd_ptr;
  logic [FIFO_LOG2:0]     level;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;

  // Channel index 0 is left, 1 is right.
  logic signed [15:0]      prev    [2];
  logic signed [15:0]      cur     [2];
  logic signed [15:0]      cur_nxt [2];
  logic signed [15:0]      head    [2];
  logic signed [16:0]      delta   [2];
  logic signed [ACC_W-1:0] acc     [2];
  logic [15:0]             d_q     [2];

  assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
  assign boundary   = tick && (phase == '1);
  assign fifo_empty = (level == '0);
  assign push       = in_bus.in_valid && in_bus.in_ready;
  assign pop        = boundary && !fifo_empty;

  // Full blocks a push even when a boundary pop frees a slot in the same cycle.
  assign in_bus.in_ready = !reset && (level != (FIFO_LOG2+1)'(DEPTH));

  assign fifo_level = level;
  assign d_l        = d_q[0];
  assign d_r        = d_q[1];
  assign head[0]    = mem[rd_ptr][31:16];
  assign head[1]    = mem[rd_ptr][15:0];

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      cur_nxt[ch] = cur[ch];
      if (mute)
        cur_nxt[ch] = '0;
      else if (!fifo_empty)
        cur_nxt[ch] = head[ch];
    end
  end

  // Storage is not reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {in_bus.in_l, in_bus.in_r};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      tick_q   <= 1'b0;
      phase    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      underrun <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        prev[ch]  <= '0;
        cur[ch]   <= '0;
        delta[ch] <= '0;
        acc[ch]   <= '0;
        d_q[ch]   <= 16'h8000;
      end
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      tick_q   <= tick;

      if (push)
        wr_ptr <= wr_ptr + FIFO_LOG2'(1);
      if (pop)
        rd_ptr <= rd_ptr + FIFO_LOG2'(1);
      case ({push, pop})
        2'b10:   level <= level + (FIFO_LOG2+1)'(1);
        2'b01:   level <= level - (FIFO_LOG2+1)'(1);
        default: level <= level;
      endcase

      underrun <= boundary && !mute && fifo_empty;

      if (tick) begin
        phase <= phase + INTERP_LOG2'(1);
        for (int ch = 0; ch < 2; ch++) begin
          if (boundary) begin
            // Restart the ramp from the old cur, which becomes the new prev.
            prev[ch]  <= cur[ch];
            cur[ch]   <= cur_nxt[ch];
            acc[ch]   <= {cur[ch][15], cur[ch], {INTERP_LOG2{1'b0}}};
            delta[ch] <= {cur_nxt[ch][15], cur_nxt[ch]} - {cur[ch][15], cur[ch]};
          end else begin
            acc[ch] <= acc[ch] + {{(ACC_W-17){delta[ch][16]}}, delta[ch]};
          end
        end
      end

      // Output register follows the accumulator one cycle later so it holds a full frame.
      if (tick_q) begin
        for (int ch = 0; ch < 2; ch++)
          d_q[ch] <= acc[ch][INTERP_LOG2 +: 16] ^ 16'h8000;
      end
    end
  end
endmodule

// File: tb/tb_audio_interp_fifo.sv
// Directed bench for audio_interp_fifo: reset, step ramps, full-scale swing, FIFO full, underrun, mute.
module tb_audio_interp_fifo;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mute = 1'b0;
  logic [15:0] d_l;
  logic [15:0] d_r;
  logic        underrun;
  logic [2:0]  fifo_level;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  audio_interp_fifo_if bus ();

  audio_interp_fifo #(.TICK_DIV(32), .INTERP_LOG2(4), .FIFO_LOG2(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_bus     (bus),
    .mute       (mute),
    .d_l        (d_l),
    .d_r        (d_r),
    .underrun   (underrun),
    .fifo_level (fifo_level)
  );

  // Clock / reset-relative cycle counter: cyc equals the DUT tick counter after reset.
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic do_reset(input int n);
    reset = 1'b1;
    mute = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_l = '0;
    bus.in_r = '0;
    repeat (n) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    @(negedge clk);
    while (cyc != target && guard < 10000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) begin
      errors++;
      checks++;
      $display("FAIL wait_cyc got=%0d exp=%0d", cyc, target);
    end
  endtask

  task automatic test_reset;
    do_reset(2);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.in_ready); end
    checks++; if (d_l !== 16'h8000) begin errors++; $display("FAIL rst_d_l got=%h exp=8000", d_l); end
    bus.in_valid = 1'b1;
    bus.in_l = 16'h1000;
    bus.in_r = 16'hF000;
    wait_cyc(600);
    checks++; if (d_l !== 16'h8200) begin errors++; $display("FAIL mid_d_l got=%h exp=8200", d_l); end
    checks++; if (d_r !== 16'h7E00) begin errors++; $display("FAIL mid_d_r got=%h exp=7e00", d_r); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL mid_level got=%0d exp=4", fifo_level); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (d_l !== 16'h8000) begin errors++; $display("FAIL rst2_d_l got=%h exp=8000", d_l); end
    checks++; if (d_r !== 16'h8000) begin errors++; $display("FAIL rst2_d_r got=%h exp=8000", d_r); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst2_level got=%0d exp=0", fifo_level); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst2_underrun got=%b exp=0", underrun); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst2_ready_held got=%b exp=0", bus.in_ready); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst2_ready_rel got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_step;
    logic [15:0] exp_l, exp_r;
    do_reset(1);
    bus.in_valid = 1'b1;
    bus.in_l = 16'h1000;
    bus.in_r = 16'hF000;
    for (int p = 0; p < 16; p++) begin
      wait_cyc(512 + 32 * p + 16);
      exp_l = 16'h8000 + 16'(p * 256);
      exp_r = 16'h8000 - 16'(p * 256);
      checks++; if (d_l !== exp_l) begin errors++; $display("FAIL step_l p=%0d got=%h exp=%h", p, d_l, exp_l); end
      checks++; if (d_r !== exp_r) begin errors++; $display("FAIL step_r p=%0d got=%h exp=%h", p, d_r, exp_r); end
    end
    wait_cyc(1040);
    checks++; if (d_l !== 16'h9000) begin errors++; $display("FAIL step_l_final got=%h exp=9000", d_l); end
    checks++; if (d_r !== 16'h7000) begin errors++; $display("FAIL step_r_final got=%h exp=7000", d_r); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_full_scale;
    logic [15:0] exp_l;
    do_reset(1);
    bus.in_valid = 1'b1;
    bus.in_l = 16'h7FFF;
    bus.in_r = 16'h0000;
    @(posedge clk); #1;
    bus.in_l = 16'h8000;
    for (int p = 0; p < 16; p++) begin
      wait_cyc(1024 + 32 * p + 16);
      exp_l = 16'hFFFF - 16'(p * 4096);
      checks++; if (d_l !== exp_l) begin errors++; $display("FAIL fs_l p=%0d got=%h exp=%h", p, d_l, exp_l); end
    end
    wait_cyc(1552);
    checks++; if (d_l !== 16'h0000) begin errors++; $display("FAIL fs_l_final got=%h exp=0000", d_l); end
    checks++; if (d_r !== 16'h8000) begin errors++; $display("FAIL fs_r got=%h exp=8000", d_r); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_fifo_full;
    logic [15:0] vals [4];
    vals[0] = 16'h0100; vals[1] = 16'h0200; vals[2] = 16'h0300; vals[3] = 16'h0400;
    do_reset(1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_l = vals[i];
      bus.in_r = -vals[i];
      @(posedge clk); #1;
    end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level got=%0d exp=4", fifo_level); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", bus.in_ready); end
    bus.in_l = 16'h7000;
    bus.in_r = 16'h7000;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_5th got=%0d exp=4", fifo_level); end
    bus.in_valid = 1'b0;
    wait_cyc(511);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_pre_pop got=%b exp=0", bus.in_ready); end
    wait_cyc(512);
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL full_pop_level got=%0d exp=3", fifo_level); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready got=%b exp=1", bus.in_ready); end
    wait_cyc(1040);
    checks++; if (d_l !== 16'h8100) begin errors++; $display("FAIL full_a_l got=%h exp=8100", d_l); end
    checks++; if (d_r !== 16'h7F00) begin errors++; $display("FAIL full_a_r got=%h exp=7f00", d_r); end
    wait_cyc(1552);
    checks++; if (d_l !== 16'h8200) begin errors++; $display("FAIL full_b_l got=%h exp=8200", d_l); end
    wait_cyc(2064);
    checks++; if (d_l !== 16'h8300) begin errors++; $display("FAIL full_c_l got=%h exp=8300", d_l); end
  endtask

  // Continues from test_fifo_full with the FIFO left to drain.
  task automatic test_underrun;
    wait_cyc(2048 + 32);
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ur_level got=%0d exp=0", fifo_level); end
    wait_cyc(2559);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_before got=%b exp=0", underrun); end
    wait_cyc(2560);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_pulse1 got=%b exp=1", underrun); end
    wait_cyc(2561);
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_after got=%b exp=0", underrun); end
    wait_cyc(2576);
    checks++; if (d_l !== 16'h8400) begin errors++; $display("FAIL ur_d_hold got=%h exp=8400", d_l); end
    wait_cyc(2864);
    checks++; if (d_l !== 16'h8400) begin errors++; $display("FAIL ur_d_mid got=%h exp=8400", d_l); end
    wait_cyc(3072);
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_pulse2 got=%b exp=1", underrun); end
    wait_cyc(3088);
    checks++; if (d_l !== 16'h8400) begin errors++; $display("FAIL ur_d_late got=%h exp=8400", d_l); end
    checks++; if (d_r !== 16'h7C00) begin errors++; $display("FAIL ur_d_r got=%h exp=7c00", d_r); end
  endtask

  task automatic test_mute;
    logic [15:0] exp_l;
    int pts [4];
    pts[0] = 0; pts[1] = 4; pts[2] = 8; pts[3] = 15;
    do_reset(1);
    bus.in_valid = 1'b1;
    bus.in_l = 16'h4000;
    bus.in_r = 16'h4000;
    wait_cyc(1040);
    checks++; if (d_l !== 16'hC000) begin errors++; $display("FAIL mute_pre got=%h exp=c000", d_l); end
    wait_cyc(1100);
    mute = 1'b1;
    wait_cyc(1535);
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL mute_level_pre got=%0d exp=4", fifo_level); end
    wait_cyc(1536);
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mute_consume got=%0d exp=3", fifo_level); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mute_underrun got=%b exp=0", underrun); end
    for (int i = 0; i < 4; i++) begin
      wait_cyc(1536 + 32 * pts[i] + 16);
      exp_l = 16'hC000 - 16'(pts[i] * 1024);
      checks++; if (d_l !== exp_l) begin errors++; $display("FAIL mute_glide p=%0d got=%h exp=%h", pts[i], d_l, exp_l); end
    end
    wait_cyc(2048);
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mute_consume2 got=%0d exp=3", fifo_level); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL mute_underrun2 got=%b exp=0", underrun); end
    wait_cyc(2064);
    checks++; if (d_l !== 16'h8000) begin errors++; $display("FAIL mute_l_final got=%h exp=8000", d_l); end
    checks++; if (d_r !== 16'h8000) begin errors++; $display("FAIL mute_r_final got=%h exp=8000", d_r); end
    mute = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_l = '0;
    bus.in_r = '0;
    test_reset();
    test_step();
    test_full_scale();
    test_fifo_full();
    test_underrun();
    test_mute();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/audio_interp_fifo.md
# audio_interp_fifo

Stereo sample buffer and linear interpolator that sits directly upstream of the hybrid PWM/sigma-delta DAC. It accepts signed 16-bit stereo samples from the audio mixer over a valid/ready handshake and buffers them in a small FIFO. It linearly interpolates between consecutive samples, presenting an offset-binary 16-bit value per channel on `d_l`/`d_r`, updated once per PWM frame. This removes the staircase images that a sample-and-hold feed produces at the DAC.

## Interface
- `TICK_DIV`, 32: clk cycles per output update; matches the DAC's 32-cycle PWM frame.
- `INTERP_LOG2`, 4: output updates per input sample = 2^INTERP_LOG2. Input rate = clk / (TICK_DIV·2^INTERP_LOG2).
- `FIFO_LOG2`, 2: FIFO depth = 2^FIFO_LOG2 stereo pairs.
- `clk`  in  1: system clock.
- `reset`  in  1: reset. One clock; reset is synchronous and active-high.
- `in_valid`  in  1: sample pair valid.
- `in_ready`  out  1: FIFO can accept a pair.
- `in_l`, `in_r`  in  16 each: signed two's-complement samples.
- `mute`  in  1: glide to silence (midpoint).
- `d_l`, `d_r`  out  16 each: offset-binary samples to the DAC (0x8000 = silence).
- `underrun`  out  1: one-cycle pulse when a sample load found the FIFO empty.
- `fifo_level`  out  FIFO_LOG2+1: current FIFO occupancy.

## Operation
- **Tick generator:** `tick_cnt` runs 0..TICK_DIV-1 and wraps. `tick` is asserted in the cycle where `tick_cnt==TICK_DIV-1`.
- **FIFO:** circular buffer of {l,r} pairs.
  - Push occurs when `in_valid & in_ready`.
  - `in_ready = (level != 2^FIFO_LOG2)`, driven combinationally from the registered level. When the FIFO is full, `in_ready` is low even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave the level unchanged.
- **Interpolator state per channel:** `prev`, `cur` (signed 16), `delta = cur - prev` (signed 17), `acc` (signed 16+INTERP_LOG2+1).
- **Phase counter:** `phase` has INTERP_LOG2 bits and advances on each `tick`.
- **On `tick` with `phase != all-ones`:** `acc <= acc + delta`.
- **On `tick` with `phase == all-ones` (boundary):**
  - `prev <= cur`.
  - `cur` loading:
    - If `mute` is high, `cur <= 0`, and a FIFO entry is popped if one is present (data discarded).
    - Otherwise, if the FIFO is non-empty, pop and `cur <= head`.
    - Otherwise (FIFO empty), `cur` holds its value and `underrun` pulses.
  - `acc <= cur << INTERP_LOG2`, using the old `cur`.
  - `delta` is recomputed from the new `prev`/`cur`.
- **Output value:** `d = (acc >>> INTERP_LOG2) ^ 16'h8000`.
  - Equivalent closed form: `prev + floor((cur-prev)·phase / 2^INTERP_LOG2)`.
  - The result is always inside [prev, cur], so it never overflows 16 bits.
- **Reset mid-operation:** all state returns to reset values on the next edge. FIFO contents are discarded.

## Timing
- **Reset values:**
  - `d_l = d_r = 16'h8000`; `in_ready = 0` while `reset` is high, then 1.
  - `underrun = 0`, `fifo_level = 0`.
  - `prev = cur = acc = delta = 0`, `phase = 0`, `tick_cnt = 0`.
- **Output updates:** `d_l`/`d_r` are registered and change only on the edge one cycle after a `tick` cycle. They are therefore stable for TICK_DIV cycles, and the DAC may sample them at any point.
- **Underrun:** `underrun` is registered, high for exactly one cycle, and coincides with the boundary update.
- **`fifo_level`:** updates on the edge after the push/pop.
- **Latency:** a pair pushed into an empty FIFO becomes `cur` at the next boundary. The output reaches that value exactly at the following boundary. Worst case is 2·2^INTERP_LOG2·TICK_DIV cycles plus 1.
- **`mute`:** sampled only at boundaries.

## Test plan
- **Reset:** hold `reset` 3 cycles mid-stream → next cycle `d_l = d_r = 0x8000`, `fifo_level = 0`, `in_ready = 1` after release, `underrun = 0`.
- **Step response:** keep the FIFO fed with `in_l = 0x1000`, `in_r = 0xF000` → after the step, `d_l` rises in 16 steps of 0x0100 to 0x9000; `d_r` falls in 16 steps of 0x0100 to 0x7000; each step is one per 32 clk.
- **Full-scale transition:** `in_l` goes 0x7FFF → 0x8000 → outputs are monotonic 0xFFFF … 0x0000 with no wrap; final value 0x0000.
- **FIFO full:** push 4 pairs with no boundary in between → `in_ready` low after the 4th, `fifo_level = 4`. A 5th push is not accepted and not stored. After the next boundary pop, `in_ready` returns high.
- **Underrun:** stop feeding → `underrun` pulses once per boundary; output holds the last `cur` value exactly with no drift.
- **Mute:** assert `mute` with a constant 0x4000 feed → glides to 0x8000 over 16 ticks after the next boundary. FIFO entries are still consumed, and `underrun` stays low while data is present.
